char_console_writer: RTL and testbench
======================================

// Module: char_console_writer
// PURPOSE
//   Turns an ASCII byte stream (from CPU I/O or UART) into writes to the screen char RAM.
//   Tracks a cursor and interprets CR, LF, BS and FF.
//   Clears lines and the whole screen without CPU help.
//   Sits directly upstream of char_ram and drives its write port.
// PARAMETERS
//   COLS          80          characters per row
//   ROWS          25          rows per screen; COLS*ROWS must be <= 2048
//   BLINK_CYCLES  16_000_000  cursor half-period in CLK cycles; used only with CHAR_CURSOR_EN
// PORTS
//   CLK                  in   1   system clock; all logic on posedge
//   RST                  in   1   synchronous, active-high reset
//   in_data              in   8   ASCII byte
//   in_valid             in   1   in_data is valid
//   in_ready             out  1   block can accept a byte; transfer = in_valid & in_ready
//   write_character_pos  out  11  char RAM address (row*COLS + col)
//   write_character      out  8   char RAM data
//   write_strobe         out  1   char RAM write enable, one cycle per write
//   cursor_pos           out  11  cursor address; present only with CHAR_CURSOR_EN
//   cursor_on            out  1   cursor blink phase; present only with CHAR_CURSOR_EN
// BEHAVIOUR
//   - Clock and reset: one clock, CLK. RST is synchronous and active-high.
//   - All outputs are registered. On RST, every output is 0 and state is CLR_ALL.
//   - The cursor (row, col, linear pos) resets to (0, 0, 0).
//   - The linear pos is kept incrementally; no multiplier. All address arithmetic is 11-bit.
//   - States:
//     - CLR_ALL: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE.
//       in_ready=0 throughout.
//     - IDLE: in_ready=1.
//     - CLR_LINE: writes 0x20 to the COLS cells of cursor row, one per cycle.
//       in_ready=0 throughout, then returns to IDLE.
//   - Write timing: a byte accepted in cycle N produces its write_strobe in cycle N+1.
//   - Byte decode (on accept in IDLE):
//     - 0x20..0x7E: write byte at cursor, then col+1.
//       - If col was COLS-1: col=0, row+1, enter CLR_LINE.
//     - 0x0A (LF): col=0, row+1, enter CLR_LINE. LF implies CR.
//     - 0x0D (CR): col=0, no write.
//     - 0x08 (BS): if col>0, col-1 and write 0x20 at the new cursor. At col 0: no-op.
//     - 0x0C (FF): cursor to (0,0), enter CLR_ALL.
//     - Any other byte: accepted and dropped, no write.
//   - Row wrap: row ROWS-1 +1 wraps to row 0, which is then cleared by CLR_LINE.
//     There is no hardware scroll.
//   - Back-to-back printables are accepted every cycle until a column wrap occurs.
//   - Reset during CLR_LINE or CLR_ALL aborts the clear. Outputs go to 0 next cycle.
//     A fresh full clear then starts.
//   - in_valid held high while in_ready=0: the byte is held, not lost. No other stall source exists.
// CONFIGURATION
//   - CHAR_CURSOR_EN defined:
//     - cursor_pos tracks the cursor address.
//     - cursor_on toggles every BLINK_CYCLES, and forces to 1 for one full half-period after each accept.
//     - Both reset to 0.
//   - CHAR_CURSOR_EN undefined: these ports and the blink counter are absent. All else is identical.
// STRUCTURE
//   - Shared header char_defs.vh (constants only):
//     - ASCII codes: SPACE, LF, CR, BS, FF.
//     - Default COLS/ROWS.
//     - State encodings CLR_ALL / IDLE / CLR_LINE.
//   - One sub-module, char_cursor_blink, holds the blink counter.
//     Instantiated only under CHAR_CURSOR_EN.
// TESTING
//   1. Reset release -> 2000 strobes at pos 0..1999, all 0x20, in_ready=0.
//      Then in_ready=1 on cycle 2001.
//   2. Send "AB" back-to-back -> writes 0x41@0, then 0x42@1 on consecutive cycles.
//      cursor_pos=2 (with CHAR_CURSOR_EN).
//   3. Send 80 x 'x' -> last write 0x78@79, then 80 clears @80..159.
//      Next 'y' writes @80.
//   4. At (1,5): send BS -> 0x20@84, cursor 84. At (1,0): send BS -> no strobe, cursor unchanged.
//   5. At row 24: send LF -> clears @0..79, cursor 0. Send FF mid-screen -> full clear, then cursor 0.
//   6. Assert RST mid-CLR_LINE -> write_strobe=0 next cycle, then full clear restarts at pos 0.
//      Byte 0x07 accepted -> no strobe.

Source files
------------

// File: rtl/char_console_writer_pkg.sv
// Shared constants for the character console writer: ASCII control codes,
// default screen geometry and the FSM state encoding.
package char_console_writer_pkg;

  localparam int AW       = 11;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 25;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_console_writer_cursor_blink.sv
// Cursor blink phase generator; present only when CHAR_CURSOR_EN is defined.
// Every accepted byte restarts the half-period with the cursor shown.
module char_cursor_blink #(
  parameter int BLINK_CYCLES = 16_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic kick_i,
  output logic cursor_on_o
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          on_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= RELOAD;
      on_q  <= 1'b0;
    end else if (kick_i) begin
      cnt_q <= RELOAD;
      on_q  <= 1'b1;
    end else if (cnt_q == '0) begin
      cnt_q <= RELOAD;
      on_q  <= ~on_q;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign cursor_on_o = on_q;

endmodule

// File: rtl/char_console_writer.sv
// Byte stream to char RAM writer with cursor tracking and self-driven clears.
// Optional cursor outputs and blink counter are enabled by CHAR_CURSOR_EN.
//   state    | meaning
//   CLR_ALL  | writing spaces over the whole screen, input stalled
//   IDLE     | accepting bytes
//   CLR_LINE | writing spaces over the cursor row, input stalled
module char_console_writer
  import char_console_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
`ifdef CHAR_CURSOR_EN
  , parameter int BLINK_CYCLES = 16_000_000
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] write_character_pos,
  output logic [7:0]    write_character,
  output logic          write_strobe
`ifdef CHAR_CURSOR_EN
  , output logic [AW-1:0] cursor_pos
  , output logic          cursor_on
`endif
);

  localparam logic [AW-1:0] COLS_A  = AW'(COLS);
  localparam logic [AW-1:0] ROWS_A  = AW'(ROWS);
  // One bit wider than an address so a full 2048-cell screen still fits.
  localparam logic [AW:0]   TOTAL_C = (AW+1)'(COLS * ROWS);
  localparam logic [AW:0]   LINE_C  = (AW+1)'(COLS);

  state_e        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d, pos_q, pos_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] wpos_q, wpos_d;
  logic [7:0]    wchr_q, wchr_d;
  logic          wstb_q, wstb_d, rdy_q, rdy_d;
  logic          accept, new_line;

  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pos_d      = pos_q;
    clr_addr_d = clr_addr_q;
    clr_cnt_d  = clr_cnt_q;
    wpos_d     = wpos_q;
    wchr_d     = wchr_q;
    wstb_d     = 1'b0;
    new_line   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            wstb_d = 1'b1;
            wpos_d = pos_q;
            wchr_d = in_data;
            if (col_q == COLS_A - 11'd1) begin
              new_line = 1'b1;
            end else begin
              col_d = col_q + 11'd1;
              pos_d = pos_q + 11'd1;
            end
          end else begin
            case (in_data)
              CH_LF: new_line = 1'b1;
              CH_CR: begin
                col_d = '0;
                pos_d = pos_q - col_q;
              end
              CH_BS: begin
                if (col_q != '0) begin
                  col_d  = col_q - 11'd1;
                  pos_d  = pos_q - 11'd1;
                  wstb_d = 1'b1;
                  wpos_d = pos_q - 11'd1;
                  wchr_d = CH_SPACE;
                end
              end
              CH_FF: begin
                row_d      = '0;
                col_d      = '0;
                pos_d      = '0;
                clr_addr_d = '0;
                clr_cnt_d  = TOTAL_C;
                state_d    = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_ALL, CLR_LINE: begin
        // The extra cycle at count zero keeps in_ready low until after the last strobe.
        if (clr_cnt_q != '0) begin
          wstb_d     = 1'b1;
          wpos_d     = clr_addr_q;
          wchr_d     = CH_SPACE;
          clr_addr_d = clr_addr_q + 11'd1;
          clr_cnt_d  = clr_cnt_q - 12'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = CLR_ALL;
        clr_addr_d = '0;
        clr_cnt_d  = TOTAL_C;
      end
    endcase

    if (new_line) begin
      col_d     = '0;
      state_d   = CLR_LINE;
      clr_cnt_d = LINE_C;
      if (row_q == ROWS_A - 11'd1) begin
        row_d = '0;
        pos_d = '0;
      end else begin
        row_d = row_q + 11'd1;
        pos_d = pos_q - col_q + COLS_A;
      end
      clr_addr_d = pos_d;
    end

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CLR_ALL;
      row_q      <= '0;
      col_q      <= '0;
      pos_q      <= '0;
      clr_addr_q <= '0;
      clr_cnt_q  <= TOTAL_C;
      wpos_q     <= '0;
      wchr_q     <= '0;
      wstb_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pos_q      <= pos_d;
      clr_addr_q <= clr_addr_d;
      clr_cnt_q  <= clr_cnt_d;
      wpos_q     <= wpos_d;
      wchr_q     <= wchr_d;
      wstb_q     <= wstb_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready            = rdy_q;
  assign write_character_pos = wpos_q;
  assign write_character     = wchr_q;
  assign write_strobe        = wstb_q;

`ifdef CHAR_CURSOR_EN
  char_cursor_blink #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .CLK         (CLK),
    .RST         (RST),
    .kick_i      (accept),
    .cursor_on_o (cursor_on)
  );
  assign cursor_pos = pos_q;
`endif

endmodule

// File: tb/tb_char_console_writer.sv
// Self-checking bench for char_console_writer: a screen-level model turns each
// accepted byte into the list of char RAM writes it should cause.
module tb_char_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int TOTAL = COLS * ROWS;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] write_character_pos;
  logic [7:0]  write_character;
  logic        write_strobe;
`ifdef CHAR_CURSOR_EN
  logic [10:0] cursor_pos;
  logic        cursor_on;
`endif

  char_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .write_character_pos (write_character_pos),
    .write_character     (write_character),
    .write_strobe        (write_strobe)
`ifdef CHAR_CURSOR_EN
    , .cursor_pos        (cursor_pos)
    , .cursor_on         (cursor_on)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Observed writes
  bit mon_en = 1'b0;
  int got_pos[$], got_ch[$], got_cyc[$];
  always @(negedge CLK) begin
    if (mon_en && write_strobe === 1'b1) begin
      got_pos.push_back(int'(write_character_pos));
      got_ch.push_back(int'(write_character));
      got_cyc.push_back(cyc);
    end
  end

  // Reference model: cursor as (row, col), writes as a list of (addr, char)
  int m_row = 0, m_col = 0;
  int exp_pos[$], exp_ch[$];
  logic [7:0] tx_q[$];

  function automatic void m_clear_row(int r);
    for (int c = 0; c < COLS; c++) begin
      exp_pos.push_back(r * COLS + c);
      exp_ch.push_back(32);
    end
  endfunction

  function automatic void m_accept(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_pos.push_back(m_row * COLS + m_col);
      exp_ch.push_back(int'(b));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        m_clear_row(m_row);
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      m_clear_row(m_row);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_pos.push_back(m_row * COLS + m_col);
        exp_ch.push_back(32);
      end
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int r = 0; r < ROWS; r++) m_clear_row(r);
    end
  endfunction

  function automatic void push_str(string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endfunction

  // Presents tx_q bytes, holding each until the DUT accepts it
  task automatic send_all();
    int guard = 0;
    logic rdy;
    @(negedge CLK);
    while (tx_q.size() > 0 && guard < 20000) begin
      in_valid = 1'b1;
      in_data  = tx_q[0];
      rdy      = in_ready;
      @(negedge CLK);
      guard++;
      if (rdy) begin
        m_accept(tx_q[0]);
        void'(tx_q.pop_front());
      end
    end
    in_valid = 1'b0;
    if (tx_q.size() > 0) begin
      errors++;
      $display("FAIL send_timeout: %0d bytes still pending, expected 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge CLK);
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%0b, expected 1", in_ready);
    end
  endtask

  task automatic check_sb(string name);
    int bad = -1;
    int n;
    checks++;
    if (got_pos.size() != exp_pos.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, got_pos.size(), exp_pos.size());
    end
    n = (got_pos.size() < exp_pos.size()) ? got_pos.size() : exp_pos.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && (got_pos[i] != exp_pos[i] || got_ch[i] != exp_ch[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_data: write %0d got 0x%02h@%0d, expected 0x%02h@%0d",
               name, bad, got_ch[bad], got_pos[bad], exp_ch[bad], exp_pos[bad]);
    end
`ifdef CHAR_CURSOR_EN
    checks++;
    if (int'(cursor_pos) != m_row * COLS + m_col) begin
      errors++;
      $display("FAIL %s_cursor: got %0d, expected %0d", name, cursor_pos, m_row * COLS + m_col);
    end
`endif
  endtask

  task automatic clear_sb();
    got_pos.delete(); got_ch.delete(); got_cyc.delete();
    exp_pos.delete(); exp_ch.delete();
  endtask

  // Holds reset, then checks the full-screen clear strobe by strobe
  task automatic reset_and_check(string name);
    int bad = 0, bad_k = -1;
    logic [10:0] bpos;
    logic bstb, brdy;
    mon_en = 1'b0;
    RST = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || write_strobe !== 1'b0 || write_character_pos !== 11'd0 ||
        write_character !== 8'h00) begin
      errors++;
      $display("FAIL %s_reset_outputs: rdy=%0b stb=%0b pos=%0d chr=0x%02h, expected all 0",
               name, in_ready, write_strobe, write_character_pos, write_character);
    end
    RST = 1'b0;
    for (int k = 0; k < TOTAL; k++) begin
      @(negedge CLK);
      if (write_strobe !== 1'b1 || int'(write_character_pos) != k ||
          write_character !== 8'h20 || in_ready !== 1'b0) begin
        if (bad == 0) begin
          bad_k = k; bpos = write_character_pos; bstb = write_strobe; brdy = in_ready;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_clear_all: cycle %0d stb=%0b pos=%0d rdy=%0b, expected stb=1 pos=%0d rdy=0",
               name, bad_k + 1, bstb, bpos, brdy, bad_k);
    end
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || write_strobe !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_after_clear: rdy=%0b stb=%0b, expected rdy=1 stb=0",
               name, in_ready, write_strobe);
    end
    m_row = 0;
    m_col = 0;
    clear_sb();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    reset_and_check("reset");
  endtask

  task automatic test_back_to_back();
    push_str("AB");
    send_all();
    wait_idle();
    check_sb("ab");
    checks++;
    if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 1) begin
      errors++;
      $display("FAIL ab_consecutive: %0d writes, gap %0d, expected 2 writes gap 1",
               got_cyc.size(), (got_cyc.size() == 2) ? got_cyc[1] - got_cyc[0] : -1);
    end
    clear_sb();
  endtask

  task automatic test_col_wrap();
    tx_q.push_back(8'h0D);
    for (int i = 0; i < COLS; i++) tx_q.push_back(8'h78);
    tx_q.push_back(8'h79);
    send_all();
    wait_idle();
    check_sb("col_wrap");
    checks++;
    if (got_pos.size() == 0 || got_pos[got_pos.size()-1] != COLS || got_ch[got_ch.size()-1] != 8'h79) begin
      errors++;
      $display("FAIL col_wrap_y: last write 0x%02h@%0d, expected 0x79@%0d",
               (got_ch.size() > 0) ? got_ch[got_ch.size()-1] : -1,
               (got_pos.size() > 0) ? got_pos[got_pos.size()-1] : -1, COLS);
    end
    clear_sb();
  endtask

  task automatic test_backspace();
    push_str("abcd");
    tx_q.push_back(8'h08);
    send_all();
    wait_idle();
    check_sb("bs_mid");
    checks++;
    if (got_pos.size() == 0 || got_pos[got_pos.size()-1] != COLS + 4 || got_ch[got_ch.size()-1] != 32) begin
      errors++;
      $display("FAIL bs_mid_write: last write at %0d, expected 0x20@%0d",
               (got_pos.size() > 0) ? got_pos[got_pos.size()-1] : -1, COLS + 4);
    end
    clear_sb();
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h08);
    send_all();
    wait_idle();
    checks++;
    if (got_pos.size() != 0) begin
      errors++;
      $display("FAIL bs_col0: got %0d writes, expected 0", got_pos.size());
    end
    check_sb("bs_col0");
    clear_sb();
  endtask

  task automatic test_row_wrap_and_ff();
    while (m_row != ROWS - 1) begin
      tx_q.push_back(8'h0A);
      send_all();
    end
    wait_idle();
    clear_sb();
    tx_q.push_back(8'h0A);
    send_all();
    wait_idle();
    check_sb("row_wrap");
    checks++;
    if (m_row != 0 || exp_pos.size() != COLS || (got_pos.size() > 0 && got_pos[0] != 0)) begin
      errors++;
      $display("FAIL row_wrap_first: first write %0d, expected 0",
               (got_pos.size() > 0) ? got_pos[0] : -1);
    end
    clear_sb();
    push_str("Hello");
    tx_q.push_back(8'h0A);
    push_str("mid");
    tx_q.push_back(8'h0C);
    tx_q.push_back(8'h51);
    send_all();
    wait_idle();
    check_sb("form_feed");
    clear_sb();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 68)      tx_q.push_back(8'($urandom_range(32, 126)));
      else if (r < 76) tx_q.push_back(8'h0A);
      else if (r < 83) tx_q.push_back(8'h0D);
      else if (r < 94) tx_q.push_back(8'h08);
      else if (r < 96) tx_q.push_back(8'h0C);
      else             tx_q.push_back(8'($urandom_range(0, 255)));
    end
    send_all();
    wait_idle();
    check_sb("random");
    clear_sb();
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    tx_q.push_back(8'h0A);
    send_all();
    while (write_strobe !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (write_strobe !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_strobe: stb=%0b rdy=%0b, expected 0 0", write_strobe, in_ready);
    end
    reset_and_check("mid_reset");
    tx_q.push_back(8'h07);
    send_all();
    wait_idle();
    checks++;
    if (got_pos.size() != 0) begin
      errors++;
      $display("FAIL bell_dropped: got %0d writes, expected 0", got_pos.size());
    end
    tx_q.push_back(8'h5A);
    send_all();
    wait_idle();
    check_sb("after_bell");
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_col_wrap();
    test_backspace();
    test_row_wrap_and_ff();
    test_random();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
